wb_unit: RTL and testbench

Parametrised write-back stage for the RV pipeline. It sits after the MEM/WB pipeline register and in front of the register file. It selects the write-back source (ALU, aligned load data, PC+4, immediate) and aligns and sign-extends sub-word loads. It stalls the MEM/WB register while a load response is outstanding, drives a registered register-file write port that doubles as the forwarding source, and counts retired instructions.

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_unit_if.sv | 44 ++++
 rtl/wb_unit_load_align.sv | 61 ++++++
 rtl/wb_unit.sv | 131 +++++++++++++
 tb/tb_wb_unit.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the write-back stage.
//   - MemtoReg source encodings (WB_ALU, WB_MEM, WB_PC4, WB_IMM)
//   - load FUNCT3 codes (LB, LH, LW, LD, LBU, LHU, LWU)
//   - write-back FSM state enum
package wb_pkg;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_unit_if.sv
// wb_unit_if: MEM/WB slot, memory response and register-file write port of
// the write-back stage, bundled as one interface.
//   master : pipeline/memory side (drives the slot and the load response,
//            observes READY_WB, the RF write port, LOAD_ERR and INSTRET)
//   slave  : wb_unit side
interface wb_unit_if #(
    parameter int XLEN  = 32,
    parameter int REGS  = 32,
    parameter int CNT_W = 64
);
    localparam int AW = $clog2(REGS);
    localparam int OW = $clog2(XLEN / 8);

    logic             VALID_MW;
    logic             READY_WB;
    logic [XLEN-1:0]  ALU_MW;
    logic [XLEN-1:0]  PC4_MW;
    logic [XLEN-1:0]  IMM_MW;
    logic [AW-1:0]    RD_MW;
    logic [1:0]       MemtoReg_MW;
    logic             RegWrite_MW;
    logic [2:0]       FUNCT3_MW;
    logic [OW-1:0]    ADDR_LO_MW;
    logic             MEM_RSP_VALID;
    logic [XLEN-1:0]  MEM_RSP_DATA;
    logic             RF_WE;
    logic [AW-1:0]    RF_WA;
    logic [XLEN-1:0]  RF_WD;
    logic             LOAD_ERR;
    logic [CNT_W-1:0] INSTRET;

    modport master (
        output VALID_MW, ALU_MW, PC4_MW, IMM_MW, RD_MW, MemtoReg_MW,
               RegWrite_MW, FUNCT3_MW, ADDR_LO_MW, MEM_RSP_VALID, MEM_RSP_DATA,
        input  READY_WB, RF_WE, RF_WA, RF_WD, LOAD_ERR, INSTRET
    );

    modport slave (
        input  VALID_MW, ALU_MW, PC4_MW, IMM_MW, RD_MW, MemtoReg_MW,
               RegWrite_MW, FUNCT3_MW, ADDR_LO_MW, MEM_RSP_VALID, MEM_RSP_DATA,
        output READY_WB, RF_WE, RF_WA, RF_WD, LOAD_ERR, INSTRET
    );

endinterface

// File: rtl/wb_unit_load_align.sv
// load_align: combinational load aligner.
//   data   in  XLEN  naturally aligned memory word/dword
//   funct3 in  3     load size and signedness
//   offset in  OW    byte offset of the load inside data
//   value  out XLEN  selected field, sign- or zero-extended
//   err    out 1     misaligned access or FUNCT3 illegal for this XLEN
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]              data,
    input  logic [2:0]                   funct3,
    input  logic [$clog2(XLEN/8)-1:0]    offset,
    output logic [XLEN-1:0]              value,
    output logic                         err
);

    logic [XLEN-1:0]    shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] word_s;

    // Bring the addressed byte down to bit 0; field extraction is then fixed.
    assign shifted = data >> {offset, 3'b000};
    assign byte_s  = shifted[7:0];
    assign half_s  = shifted[15:0];
    assign word_s  = shifted[31:0];

    always_comb begin
        value = '0;
        err   = 1'b0;
        case (funct3)
            LB:  value = XLEN'(byte_s);
            LBU: value = XLEN'(shifted[7:0]);
            LH: begin
                value = XLEN'(half_s);
                err   = offset[0];
            end
            LHU: begin
                value = XLEN'(shifted[15:0]);
                err   = offset[0];
            end
            LW: begin
                value = XLEN'(word_s);
                err   = (offset[1:0] != 2'b00);
            end
            // LWU and LD only exist on RV64.
            LWU: begin
                value = XLEN'(shifted[31:0]);
                err   = (XLEN == 32) || (offset[1:0] != 2'b00);
            end
            LD: begin
                value = shifted;
                err   = (XLEN == 32) || (offset != '0);
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// wb_unit: write-back stage between the MEM/WB register and the register file.
//   CLK  in  clock, rising edge
//   RST  in  asynchronous active-high reset
//   bus  slave modport of wb_unit_if:
//        MEM/WB slot (VALID_MW/READY_WB, ALU/PC4/IMM, RD, MemtoReg, RegWrite,
//        FUNCT3, ADDR_LO), load response (MEM_RSP_VALID/DATA), registered
//        RF write port (RF_WE/WA/WD, also the forwarding source), LOAD_ERR
//        pulse and the INSTRET retired-instruction counter.
module wb_unit
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int REGS  = 32,
    parameter int CNT_W = 64
) (
    input  logic     CLK,
    input  logic     RST,
    wb_unit_if.slave bus
);

    localparam int AW = $clog2(REGS);
    localparam int OW = $clog2(XLEN / 8);

    wb_state_t        state;
    logic [AW-1:0]    hold_rd;
    logic             hold_we;
    logic [2:0]       hold_f3;
    logic [OW-1:0]    hold_lo;

    logic             in_wait, accept, is_load;
    logic             complete, cmp_load, cmp_we, cmp_err;
    logic [AW-1:0]    cmp_rd;
    logic [2:0]       al_f3;
    logic [OW-1:0]    al_lo;
    logic [XLEN-1:0]  al_val, result;
    logic             al_err;

    logic             rf_we_p1;
    logic [AW-1:0]    rf_wa_p1;
    logic [XLEN-1:0]  rf_wd_p1;
    logic             load_err_p1;
    logic [CNT_W-1:0] instret_p1;

    assign in_wait = (state == WAIT_MEM);
    assign accept  = bus.VALID_MW && !in_wait;
    assign is_load = (bus.MemtoReg_MW == WB_MEM);

    // While waiting, the MEM/WB register is frozen but may carry anything;
    // the aligner must see the latched load attributes instead.
    assign al_f3 = in_wait ? hold_f3 : bus.FUNCT3_MW;
    assign al_lo = in_wait ? hold_lo : bus.ADDR_LO_MW;

    load_align #(.XLEN(XLEN)) u_align (
        .data   (bus.MEM_RSP_DATA),
        .funct3 (al_f3),
        .offset (al_lo),
        .value  (al_val),
        .err    (al_err)
    );

    always_comb begin
        cmp_load = in_wait || is_load;
        complete = in_wait ? bus.MEM_RSP_VALID
                           : (accept && (!is_load || bus.MEM_RSP_VALID));
        cmp_rd   = in_wait ? hold_rd : bus.RD_MW;
        cmp_we   = in_wait ? hold_we : bus.RegWrite_MW;
        cmp_err  = cmp_load && al_err;
        result   = '0;
        if (cmp_load) begin
            result = al_val;
        end else begin
            case (bus.MemtoReg_MW)
                WB_PC4:  result = bus.PC4_MW;
                WB_IMM:  result = bus.IMM_MW;
                default: result = bus.ALU_MW;
            endcase
        end
    end

    // ---- stage p1: completion -> registered RF write port / counter ----
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            hold_rd     <= '0;
            hold_we     <= 1'b0;
            hold_f3     <= '0;
            hold_lo     <= '0;
            rf_we_p1    <= 1'b0;
            rf_wa_p1    <= '0;
            rf_wd_p1    <= '0;
            load_err_p1 <= 1'b0;
            instret_p1  <= '0;
        end else begin
            rf_we_p1    <= 1'b0;
            load_err_p1 <= 1'b0;
            if (complete) begin
                if (cmp_err) begin
                    load_err_p1 <= 1'b1;
                end else begin
                    rf_we_p1   <= cmp_we && (cmp_rd != '0);
                    rf_wa_p1   <= cmp_rd;
                    rf_wd_p1   <= result;
                    instret_p1 <= instret_p1 + 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (accept && is_load && !bus.MEM_RSP_VALID) begin
                        hold_rd <= bus.RD_MW;
                        hold_we <= bus.RegWrite_MW;
                        hold_f3 <= bus.FUNCT3_MW;
                        hold_lo <= bus.ADDR_LO_MW;
                        state   <= WAIT_MEM;
                    end
                end
                WAIT_MEM: begin
                    if (bus.MEM_RSP_VALID) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.READY_WB = !in_wait;
    assign bus.RF_WE    = rf_we_p1;
    assign bus.RF_WA    = rf_wa_p1;
    assign bus.RF_WD    = rf_wd_p1;
    assign bus.LOAD_ERR = load_err_p1;
    assign bus.INSTRET  = instret_p1;

endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit: randomized bench for wb_unit with an XLEN=32 and an XLEN=64
// instance sharing clock and reset. Expected results come from a
// behavioural load/retire model kept in the bench.
module tb_wb_unit;
    import wb_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 CLK = ~CLK;

    wb_unit_if #(.XLEN(32)) b32 ();
    wb_unit_if #(.XLEN(64)) b64 ();

    wb_unit #(.XLEN(32)) dut32 (.CLK(CLK), .RST(RST), .bus(b32.slave));
    wb_unit #(.XLEN(64)) dut64 (.CLK(CLK), .RST(RST), .bus(b64.slave));

    // model state: what the RF port / counters must show after the last edge
    logic        e32_we, e32_err;
    logic [4:0]  e32_wa;
    logic [31:0] e32_wd;
    logic [63:0] e32_cnt;
    logic        e64_we, e64_err;
    logic [4:0]  e64_wa;
    logic [63:0] e64_wd;
    logic [63:0] e64_cnt;

    function automatic logic [102:0] obs32();
        return {b32.RF_WE, b32.LOAD_ERR, b32.RF_WA, b32.RF_WD, b32.INSTRET};
    endfunction
    function automatic logic [102:0] exp32();
        return {e32_we, e32_err, e32_wa, e32_wd, e32_cnt};
    endfunction
    function automatic logic [134:0] obs64();
        return {b64.RF_WE, b64.LOAD_ERR, b64.RF_WA, b64.RF_WD, b64.INSTRET};
    endfunction
    function automatic logic [134:0] exp64();
        return {e64_we, e64_err, e64_wa, e64_wd, e64_cnt};
    endfunction

    // Load semantics from size/sign rules: returns {err, value}.
    function automatic logic [64:0] ref_load(input int xlen, input logic [63:0] data,
                                             input logic [2:0] f3, input int off);
        int nb;
        logic [63:0] raw, mask;
        logic err;
        nb   = 1 << f3[1:0];
        err  = (f3 == 3'b111) || (xlen == 32 && (f3 == 3'b011 || f3 == 3'b110))
               || ((off % nb) != 0);
        raw  = data >> (off * 8);
        mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (nb * 8)) - 64'd1);
        raw  = raw & mask;
        if (!f3[2] && raw[nb*8-1]) raw = raw | ~mask;
        if (xlen == 32) raw = raw & 64'h0000_0000_FFFF_FFFF;
        return {err, raw};
    endfunction

    function automatic logic [31:0] ref_sel(input logic [1:0] ms, input logic [31:0] alu,
                                            input logic [31:0] pc4, input logic [31:0] imm);
        return (ms == WB_PC4) ? pc4 : (ms == WB_IMM) ? imm : alu;
    endfunction

    task automatic m32_idle(); e32_we = 1'b0; e32_err = 1'b0; endtask
    task automatic m64_idle(); e64_we = 1'b0; e64_err = 1'b0; endtask
    task automatic m_reset();
        e32_we = 0; e32_err = 0; e32_wa = 0; e32_wd = 0; e32_cnt = 0;
        e64_we = 0; e64_err = 0; e64_wa = 0; e64_wd = 0; e64_cnt = 0;
    endtask
    task automatic m32_done(input logic rw, input logic [4:0] rd, input logic [31:0] v, input logic err);
        if (err) begin
            e32_we = 1'b0; e32_err = 1'b1;
        end else begin
            e32_we = rw && (rd != 0); e32_err = 1'b0;
            e32_wa = rd; e32_wd = v; e32_cnt = e32_cnt + 1;
        end
    endtask
    task automatic m64_done(input logic rw, input logic [4:0] rd, input logic [63:0] v, input logic err);
        if (err) begin
            e64_we = 1'b0; e64_err = 1'b1;
        end else begin
            e64_we = rw && (rd != 0); e64_err = 1'b0;
            e64_wa = rd; e64_wd = v; e64_cnt = e64_cnt + 1;
        end
    endtask

    task automatic tick(); @(posedge CLK); #1; endtask

    task automatic drv32(input logic v, input logic [1:0] ms, input logic rw, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic [31:0] imm,
                         input logic rv, input logic [31:0] rdat);
        b32.VALID_MW = v;  b32.MemtoReg_MW = ms; b32.RegWrite_MW = rw; b32.RD_MW = rd;
        b32.FUNCT3_MW = f3; b32.ADDR_LO_MW = lo; b32.ALU_MW = alu; b32.PC4_MW = pc4;
        b32.IMM_MW = imm; b32.MEM_RSP_VALID = rv; b32.MEM_RSP_DATA = rdat;
    endtask

    task automatic drv64(input logic v, input logic [1:0] ms, input logic rw, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [2:0] lo, input logic [63:0] alu,
                         input logic rv, input logic [63:0] rdat);
        b64.VALID_MW = v;  b64.MemtoReg_MW = ms; b64.RegWrite_MW = rw; b64.RD_MW = rd;
        b64.FUNCT3_MW = f3; b64.ADDR_LO_MW = lo; b64.ALU_MW = alu; b64.PC4_MW = '0;
        b64.IMM_MW = '0; b64.MEM_RSP_VALID = rv; b64.MEM_RSP_DATA = rdat;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        drv32(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drv64(0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_reset();
        tick(); tick();
        n_tests++;
        if ({b32.READY_WB, obs32()} !== {1'b1, 103'd0}) begin
            n_fail++; $display("FAIL reset32 got=%h exp=ready 1, all 0", {b32.READY_WB, obs32()});
        end
        n_tests++;
        if ({b64.READY_WB, obs64()} !== {1'b1, 135'd0}) begin
            n_fail++; $display("FAIL reset64 got=%h exp=ready 1, all 0", {b64.READY_WB, obs64()});
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_alu();
        logic [1:0] ms; logic rw; logic [4:0] rd; logic [31:0] a, p, im;
        drv32(1, WB_ALU, 1, 5, 0, 0, 32'h1234, 0, 0, 0, 0);
        tick();
        m32_done(1, 5, 32'h1234, 0);
        n_tests++;
        if ({b32.RF_WE, b32.RF_WA, b32.RF_WD, b32.INSTRET} !== {1'b1, 5'd5, 32'h1234, 64'd1}) begin
            n_fail++; $display("FAIL alu_directed got=%h exp=%h",
                {b32.RF_WE, b32.RF_WA, b32.RF_WD, b32.INSTRET}, {1'b1, 5'd5, 32'h1234, 64'd1});
        end
        // back-to-back non-load traffic: one retire per cycle, READY_WB never drops
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2)) 0: ms = WB_ALU; 1: ms = WB_PC4; default: ms = WB_IMM; endcase
            rw = 1'($urandom); rd = 5'($urandom); a = $urandom; p = $urandom; im = $urandom;
            drv32(1, ms, rw, rd, 3'($urandom), 2'($urandom), a, p, im, 1'($urandom), $urandom);
            tick();
            m32_done(rw, rd, ref_sel(ms, a, p, im), 0);
            n_tests++;
            if ({b32.READY_WB, obs32()} !== {1'b1, exp32()}) begin
                n_fail++; $display("FAIL alu_b2b[%0d] got=%h exp=%h", i, {b32.READY_WB, obs32()}, {1'b1, exp32()});
            end
        end
        drv32(0, 0, 1, 7, 0, 0, 32'h55, 0, 0, 0, 0);
        tick();
        m32_idle();
        n_tests++;
        if (obs32() !== exp32()) begin
            n_fail++; $display("FAIL alu_bubble got=%h exp=%h", obs32(), exp32());
        end
    endtask

    task automatic test_load_same();
        logic [2:0] f3; logic [1:0] lo; logic [31:0] d; logic rw; logic [4:0] rd; logic [64:0] r;
        logic [2:0]  df3 [3];
        logic [1:0]  dlo [3];
        logic [31:0] dexp [3];
        df3[0] = LB;  dlo[0] = 2'd3; dexp[0] = 32'hFFFF_FF80;
        df3[1] = LBU; dlo[1] = 2'd3; dexp[1] = 32'h0000_0080;
        df3[2] = LHU; dlo[2] = 2'd2; dexp[2] = 32'h0000_80FF;
        for (int i = 0; i < 3; i++) begin
            drv32(1, WB_MEM, 1, 9, df3[i], dlo[i], 0, 0, 0, 1, 32'h80FF_7F01);
            tick();
            m32_done(1, 9, dexp[i], 0);
            n_tests++;
            if ({b32.RF_WE, b32.RF_WD} !== {1'b1, dexp[i]}) begin
                n_fail++; $display("FAIL load_directed[%0d] got=%h exp=%h", i, {b32.RF_WE, b32.RF_WD}, {1'b1, dexp[i]});
            end
        end
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom); lo = 2'($urandom); d = $urandom; rw = 1'($urandom); rd = 5'($urandom);
            r = ref_load(32, {32'd0, d}, f3, int'(lo));
            drv32(1, WB_MEM, rw, rd, f3, lo, $urandom, 0, 0, 1, d);
            tick();
            m32_done(rw, rd, r[31:0], r[64]);
            n_tests++;
            if ({b32.READY_WB, obs32()} !== {1'b1, exp32()}) begin
                n_fail++; $display("FAIL load_same[%0d] f3=%0d lo=%0d got=%h exp=%h",
                                   i, f3, lo, {b32.READY_WB, obs32()}, {1'b1, exp32()});
            end
        end
    endtask

    task automatic test_load_delayed();
        int lowcnt, w;
        logic [2:0] f3; logic [1:0] lo; logic [31:0] d; logic rw; logic [4:0] rd; logic [64:0] r;
        drv32(1, WB_MEM, 1, 12, LW, 0, 0, 0, 0, 0, 0);
        tick();
        m32_idle();
        lowcnt = 0;
        for (int k = 0; k < 3; k++) begin
            if (!b32.READY_WB) lowcnt++;
            // slot contents are scrambled while waiting: the held attributes must be used
            drv32(0, 2'($urandom), 0, 5'($urandom), 3'($urandom), 2'($urandom), $urandom,
                  $urandom, $urandom, (k == 2), (k == 2) ? 32'hDEAD_BEEF : $urandom);
            tick();
            if (k < 2) begin
                n_tests++;
                if (obs32() !== exp32()) begin
                    n_fail++; $display("FAIL delayed_wait[%0d] got=%h exp=%h", k, obs32(), exp32());
                end
            end
        end
        m32_done(1, 12, 32'hDEAD_BEEF, 0);
        n_tests++;
        if (lowcnt != 3 || b32.READY_WB !== 1'b1) begin
            n_fail++; $display("FAIL delayed_ready_low got=%0d cycles ready=%b exp=3 cycles ready=1", lowcnt, b32.READY_WB);
        end
        n_tests++;
        if ({b32.RF_WE, b32.RF_WA, b32.RF_WD} !== {1'b1, 5'd12, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL delayed_lw got=%h exp=%h", {b32.RF_WE, b32.RF_WA, b32.RF_WD}, {1'b1, 5'd12, 32'hDEAD_BEEF});
        end
        drv32(0, WB_MEM, 1, 3, LW, 0, 0, 0, 0, 1, 32'h1111_2222);
        tick();
        m32_idle();
        n_tests++;
        if ({b32.READY_WB, obs32()} !== {1'b1, exp32()}) begin
            n_fail++; $display("FAIL stale_rsp got=%h exp=%h", {b32.READY_WB, obs32()}, {1'b1, exp32()});
        end
        for (int i = 0; i < 20; i++) begin
            f3 = 3'($urandom); lo = 2'($urandom); d = $urandom; rw = 1'($urandom); rd = 5'($urandom);
            w = $urandom_range(1, 3);
            r = ref_load(32, {32'd0, d}, f3, int'(lo));
            drv32(1, WB_MEM, rw, rd, f3, lo, 0, 0, 0, 0, $urandom);
            tick();
            m32_idle();
            for (int k = 0; k < w; k++) begin
                n_tests++;
                if ({b32.READY_WB, obs32()} !== {1'b0, exp32()}) begin
                    n_fail++; $display("FAIL delayed_rand_wait[%0d.%0d] got=%h exp=%h", i, k, {b32.READY_WB, obs32()}, {1'b0, exp32()});
                end
                drv32(1'($urandom), 2'($urandom), 1'($urandom), 5'($urandom), 3'($urandom), 2'($urandom),
                      $urandom, $urandom, $urandom, (k == w - 1), (k == w - 1) ? d : $urandom);
                tick();
            end
            m32_done(rw, rd, r[31:0], r[64]);
            n_tests++;
            if ({b32.READY_WB, obs32()} !== {1'b1, exp32()}) begin
                n_fail++; $display("FAIL delayed_rand[%0d] f3=%0d lo=%0d got=%h exp=%h", i, f3, lo, {b32.READY_WB, obs32()}, {1'b1, exp32()});
            end
            drv32(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
            m32_idle();
        end
    endtask

    task automatic test_load_err();
        logic [63:0] cnt0;
        logic [2:0]  ef3 [2];
        logic [1:0]  elo [2];
        ef3[0] = LH;     elo[0] = 2'd1;
        ef3[1] = 3'b111; elo[1] = 2'd0;
        for (int i = 0; i < 2; i++) begin
            cnt0 = e32_cnt;
            drv32(1, WB_MEM, 1, 6, ef3[i], elo[i], 0, 0, 0, 1, 32'hCAFE_F00D);
            tick();
            m32_done(1, 6, 0, 1);
            n_tests++;
            if ({b32.LOAD_ERR, b32.RF_WE, b32.INSTRET} !== {1'b1, 1'b0, cnt0}) begin
                n_fail++; $display("FAIL load_err[%0d] got=%h exp=%h", i, {b32.LOAD_ERR, b32.RF_WE, b32.INSTRET}, {1'b1, 1'b0, cnt0});
            end
            drv32(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
            m32_idle();
            n_tests++;
            if (obs32() !== exp32()) begin
                n_fail++; $display("FAIL load_err_pulse[%0d] got=%h exp=%h", i, obs32(), exp32());
            end
        end
    endtask

    task automatic test_rd0_jal();
        logic [63:0] cnt0;
        cnt0 = e32_cnt;
        drv32(1, WB_ALU, 1, 0, 0, 0, 32'h0ABC, 0, 0, 0, 0);
        tick();
        m32_done(1, 0, 32'h0ABC, 0);
        n_tests++;
        if ({b32.RF_WE, b32.INSTRET} !== {1'b0, cnt0 + 64'd1}) begin
            n_fail++; $display("FAIL rd0 got=%h exp=%h", {b32.RF_WE, b32.INSTRET}, {1'b0, cnt0 + 64'd1});
        end
        drv32(1, WB_PC4, 1, 1, 0, 0, 32'h7777, 32'h104, 32'h9999, 0, 0);
        tick();
        m32_done(1, 1, 32'h104, 0);
        n_tests++;
        if ({b32.RF_WE, b32.RF_WA, b32.RF_WD, b32.INSTRET} !== {1'b1, 5'd1, 32'h104, cnt0 + 64'd2}) begin
            n_fail++; $display("FAIL jal got=%h exp=%h", {b32.RF_WE, b32.RF_WA, b32.RF_WD, b32.INSTRET},
                               {1'b1, 5'd1, 32'h104, cnt0 + 64'd2});
        end
        drv32(1, WB_IMM, 0, 4, 0, 0, 0, 0, 32'h5000, 0, 0);
        tick();
        m32_done(0, 4, 32'h5000, 0);
        n_tests++;
        if (obs32() !== exp32()) begin
            n_fail++; $display("FAIL regwrite0 got=%h exp=%h", obs32(), exp32());
        end
    endtask

    task automatic test_reset_mid_wait();
        drv32(1, WB_MEM, 1, 8, LW, 0, 0, 0, 0, 0, 0);
        tick();
        n_tests++;
        if (b32.READY_WB !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_enter got=%b exp=0", b32.READY_WB);
        end
        drv32(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        RST = 1'b1;
        #1;
        m_reset();
        n_tests++;
        if ({b32.READY_WB, obs32()} !== {1'b1, 103'd0}) begin
            n_fail++; $display("FAIL rst_mid got=%h exp=ready 1, all 0", {b32.READY_WB, obs32()});
        end
        tick();
        RST = 1'b0;
        drv32(0, WB_MEM, 1, 8, LW, 0, 0, 0, 0, 1, 32'h1234_5678);
        tick();
        n_tests++;
        if ({b32.READY_WB, obs32()} !== {1'b1, exp32()}) begin
            n_fail++; $display("FAIL rst_stale got=%h exp=%h", {b32.READY_WB, obs32()}, {1'b1, exp32()});
        end
        drv32(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_xlen64();
        logic [2:0] f3, lo; logic [63:0] d; logic rw; logic [4:0] rd; logic [64:0] r; int w;
        drv64(1, WB_MEM, 1, 3, LD, 0, 0, 1, 64'h8000_0000_0000_0001);
        tick();
        m64_done(1, 3, 64'h8000_0000_0000_0001, 0);
        n_tests++;
        if ({b64.RF_WE, b64.RF_WD} !== {1'b1, 64'h8000_0000_0000_0001}) begin
            n_fail++; $display("FAIL ld64 got=%h exp=%h", {b64.RF_WE, b64.RF_WD}, {1'b1, 64'h8000_0000_0000_0001});
        end
        drv64(1, WB_MEM, 1, 4, LW, 0, 0, 1, 64'h0000_0000_8000_0000);
        tick();
        m64_done(1, 4, 64'hFFFF_FFFF_8000_0000, 0);
        n_tests++;
        if ({b64.RF_WE, b64.RF_WD} !== {1'b1, 64'hFFFF_FFFF_8000_0000}) begin
            n_fail++; $display("FAIL lw64 got=%h exp=%h", {b64.RF_WE, b64.RF_WD}, {1'b1, 64'hFFFF_FFFF_8000_0000});
        end
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom); lo = 3'($urandom); d = {$urandom, $urandom}; rw = 1'($urandom); rd = 5'($urandom);
            w = $urandom_range(0, 2);
            r = ref_load(64, d, f3, int'(lo));
            drv64(1, WB_MEM, rw, rd, f3, lo, 0, (w == 0), d);
            for (int k = 0; k < w; k++) begin
                tick();
                drv64(0, 2'($urandom), 1'($urandom), 5'($urandom), 3'($urandom), 3'($urandom), 0,
                      (k == w - 1), (k == w - 1) ? d : 64'd0);
            end
            tick();
            m64_done(rw, rd, r[63:0], r[64]);
            n_tests++;
            if ({b64.READY_WB, obs64()} !== {1'b1, exp64()}) begin
                n_fail++; $display("FAIL load64[%0d] f3=%0d lo=%0d got=%h exp=%h", i, f3, lo, {b64.READY_WB, obs64()}, {1'b1, exp64()});
            end
            drv64(0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
            m64_idle();
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_same();
        test_load_delayed();
        test_load_err();
        test_rd0_jal();
        test_reset_mid_wait();
        test_xlen64();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
